// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM states and width default for the HI/LO multiply/divide unit.
package mul_div_unit_pkg;
  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} md_state_e;

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction
endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage <-> mul/div handshake: request fields in, busy/done and HI/LO out.
interface mul_div_unit_if import mul_div_unit_pkg::*; #(parameter int WIDTH = MD_WIDTH);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, opA, opB, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, opA, opB, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate; gives magnitudes on entry and re-applies signs on exit.
module md_sign_fix #(parameter int N = 32) (
  input  logic [N-1:0] i_val,
  input  logic         i_neg,
  output logic [N-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + N'(1)) : i_val;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; WIDTH iterations on unsigned magnitudes,
// then one FIX cycle restores signs and commits the result.
module mul_div_unit import mul_div_unit_pkg::*; #(parameter int WIDTH = MD_WIDTH) (
  input  logic          clk,
  input  logic          rstN,
  mul_div_unit_if.slave md
);
  localparam int CW = $clog2(WIDTH);

  md_state_e          r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_mul, r_sa, r_sb, r_done;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] r_acc;

  logic               w_signed_op, w_sa, w_sb, w_div0;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_addend;
  logic [WIDTH:0]     w_sum, w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_acc_next, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_orig_a, w_res_hi, w_res_lo;

  assign w_signed_op = md_is_signed(md.op);
  assign w_sa        = w_signed_op & md.opA[WIDTH-1];
  assign w_sb        = w_signed_op & md.opB[WIDTH-1];

  md_sign_fix #(.N(WIDTH))   u_mag_a  (.i_val(md.opA),                .i_neg(w_sa),        .o_val(w_mag_a));
  md_sign_fix #(.N(WIDTH))   u_mag_b  (.i_val(md.opB),                .i_neg(w_sb),        .o_val(w_mag_b));
  md_sign_fix #(.N(2*WIDTH)) u_prod   (.i_val(r_acc),                 .i_neg(r_sa ^ r_sb), .o_val(w_prod));
  md_sign_fix #(.N(WIDTH))   u_quo    (.i_val(r_acc[WIDTH-1:0]),      .i_neg(r_sa ^ r_sb), .o_val(w_quo));
  md_sign_fix #(.N(WIDTH))   u_rem    (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_sa),       .o_val(w_rem));
  md_sign_fix #(.N(WIDTH))   u_orig_a (.i_val(r_a),                   .i_neg(r_sa),        .o_val(w_orig_a));

  always_comb begin
    w_addend = r_acc[0] ? r_a : '0;
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff   = w_rem_sh - {1'b0, r_b};
    if (r_is_mul)
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    else if (!w_diff[WIDTH])
      w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    else
      w_acc_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
  end

  // Zero divisor bypasses the iteration result: quotient all ones, remainder is the dividend.
  assign w_div0   = (r_b == '0);
  assign w_res_hi = r_is_mul ? w_prod[2*WIDTH-1:WIDTH] : (w_div0 ? w_orig_a : w_rem);
  assign w_res_lo = r_is_mul ? w_prod[WIDTH-1:0]       : (w_div0 ? '1       : w_quo);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_mul <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (md.start && !md.cancel) begin
            if (md_is_arith(md.op)) begin
              r_is_mul <= (md.op == MD_MULT) || (md.op == MD_MULTU);
              r_sa     <= w_sa;
              r_sb     <= w_sb;
              r_a      <= w_mag_a;
              r_b      <= w_mag_b;
              r_acc    <= ((md.op == MD_MULT) || (md.op == MD_MULTU)) ?
                          {{WIDTH{1'b0}}, w_mag_b} : {{WIDTH{1'b0}}, w_mag_a};
              r_cnt    <= '0;
              r_state  <= S_RUN;
            end else if (md.op == MD_MTHI) begin
              r_hi <= md.opA;
            end else if (md.op == MD_MTLO) begin
              r_lo <= md.opA;
            end
          end
        end
        S_RUN: begin
          if (md.cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!md.cancel) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign md.busy = (r_state != S_IDLE);
  assign md.done = r_done;
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic reference model checked every cycle plus literal pins.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  mul_div_unit_if #(.WIDTH(W)) ifc();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rstN(rstN), .md(ifc));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} from plain 64-bit / integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    longint sp;
    int q, rm;
    r = '0;
    case (op)
      MD_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        r = sp;
      end
      MD_MULTU: r = {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        if (b == 32'h0) r = {a, 32'hffff_ffff};
        else if (a == 32'h8000_0000 && b == 32'hffff_ffff) r = {32'h0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          rm = $signed(a) % $signed(b);
          r = {rm, q};
        end
      end
      default: begin
        if (b == 32'h0) r = {a, 32'hffff_ffff};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;
  bit          m_en = 1'b0;

  // Model: an accepted arithmetic op occupies WIDTH+1 cycles, result lands with done afterwards.
  always @(posedge clk) begin
    if (!rstN) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (ifc.cancel) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
          end
        end
      end else if (ifc.start && !ifc.cancel) begin
        if (ifc.op <= 3'd3) begin
          {p_hi, p_lo} = ref_result(ifc.op, ifc.opA, ifc.opB);
          m_left = W + 1;
        end else if (ifc.op == 3'd4) m_hi = ifc.opA;
        else if (ifc.op == 3'd5) m_lo = ifc.opA;
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("model busy", 32'(ifc.busy), 32'(m_left > 0));
      chk("model done", 32'(ifc.done), 32'(m_done));
      chk("model hi", ifc.hi, m_hi);
      chk("model lo", ifc.lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = op; ifc.opA = a; ifc.opB = b;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // n = cycle index with the start cycle as 1; done expected at n=34.
  task automatic wait_done(output int n, output int bcnt);
    n = 1; bcnt = 0;
    while (!ifc.done && n < 100) begin
      if (ifc.busy) bcnt++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n, bc;
    issue(op, a, b);
    wait_done(n, bc);
    chk({name, " latency"}, n, 34);
    chk({name, " busy cycles"}, bc, 33);
    chk({name, " hi"}, ifc.hi, eh);
    chk({name, " lo"}, ifc.lo, el);
  endtask

  initial begin
    int n, bc, dn;
    ifc.start = 1'b0; ifc.cancel = 1'b0; ifc.op = 3'd0; ifc.opA = '0; ifc.opB = '0;
    repeat (3) @(negedge clk);
    m_en = 1'b1;
    chk("reset hi", ifc.hi, 32'h0);
    chk("reset lo", ifc.lo, 32'h0);
    chk("reset busy", 32'(ifc.busy), 32'h0);
    chk("reset done", 32'(ifc.done), 32'h0);
    rstN = 1'b1;

    run_op("multu", MD_MULTU, 32'hffff_ffff, 32'h2, 32'h0000_0001, 32'hffff_fffe);
    run_op("mult neg", MD_MULT, 32'hffff_ffff, 32'h2, 32'hffff_ffff, 32'hffff_fffe);
    run_op("mult big", MD_MULT, 32'hdead_0000, 32'h0000_beef, 32'hffff_e725, 32'h4983_0000);
    run_op("div neg", MD_DIV, 32'hffff_fff9, 32'h2, 32'hffff_ffff, 32'hffff_fffd);
    run_op("divu", MD_DIVU, 32'h7, 32'h2, 32'h1, 32'h3);
    run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000);
    run_op("divu by0", MD_DIVU, 32'h5, 32'h0, 32'h5, 32'hffff_ffff);
    run_op("div by0", MD_DIV, 32'hffff_fff9, 32'h0, 32'hffff_fff9, 32'hffff_ffff);

    // MTHI then MTLO back to back
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = MD_MTHI; ifc.opA = 32'hdead_beef;
    @(negedge clk);
    chk("mthi hi", ifc.hi, 32'hdead_beef);
    chk("mthi busy", 32'(ifc.busy), 32'h0);
    ifc.op = MD_MTLO; ifc.opA = 32'h0000_beef;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("mtlo lo", ifc.lo, 32'h0000_beef);
    chk("mtlo hi", ifc.hi, 32'hdead_beef);
    chk("mtlo done", 32'(ifc.done), 32'h0);

    // Second start while busy is ignored
    issue(MD_MULT, 32'h3, 32'h4);
    repeat (4) @(negedge clk);
    ifc.start = 1'b1; ifc.op = MD_MTHI; ifc.opA = 32'h0000_0123;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("busy start hi", ifc.hi, 32'hdead_beef);
    wait_done(n, bc);
    chk("busy start done", 32'(ifc.done), 32'h1);
    chk("busy start lo", ifc.lo, 32'd12);
    chk("busy start hi end", ifc.hi, 32'h0);

    // Cancel in RUN at cycle 10
    issue(MD_MULT, 32'h5, 32'h6);
    repeat (9) @(negedge clk);
    ifc.cancel = 1'b1;
    @(negedge clk);
    ifc.cancel = 1'b0;
    chk("cancel busy", 32'(ifc.busy), 32'h0);
    chk("cancel lo", ifc.lo, 32'd12);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifc.done) dn++;
    end
    chk("cancel no done", dn, 0);

    // cancel with start in IDLE, and an undefined op code
    @(negedge clk);
    ifc.start = 1'b1; ifc.cancel = 1'b1; ifc.op = MD_MTLO; ifc.opA = 32'h1111_1111;
    @(negedge clk);
    ifc.cancel = 1'b0; ifc.op = 3'd7; ifc.opA = 32'h2222_2222;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("idle cancel lo", ifc.lo, 32'd12);
    chk("undef op busy", 32'(ifc.busy), 32'h0);

    // Cancel in the FIX cycle drops the result
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (32) @(negedge clk);
    chk("fix busy", 32'(ifc.busy), 32'h1);
    ifc.cancel = 1'b1;
    @(negedge clk);
    ifc.cancel = 1'b0;
    chk("fix cancel done", 32'(ifc.done), 32'h0);
    chk("fix cancel lo", ifc.lo, 32'd12);
    repeat (3) @(negedge clk);

    // Reset mid-operation at cycle 20
    issue(MD_MULT, 32'h3, 32'h4);
    repeat (19) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    chk("midrst hi", ifc.hi, 32'h0);
    chk("midrst lo", ifc.lo, 32'h0);
    chk("midrst busy", 32'(ifc.busy), 32'h0);
    repeat (3) @(negedge clk);

    m_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide responder for the MIPS datapath. Owns the HI/LO architectural registers.
- The execute stage is the initiator: it issues MULT/MULTU/DIV/DIVU with the same 32-bit operands it feeds the Alu, and stalls on busy.
- Also services MTHI/MTLO writes.
- HI/LO are exposed continuously for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rstN  input  1  synchronous, active-low reset.
- start  input  1  request valid for one cycle. Accepted only when busy=0.
- op  input  3  operation code: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- opA  input  WIDTH  rs operand (multiplicand, dividend, or MT data).
- opB  input  WIDTH  rt operand (multiplier, divisor).
- cancel  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  operation in progress. Initiator must stall MFHI/MFLO and a new start.
- done  output  1  one-cycle pulse on the cycle HI/LO first show the result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rstN=0 at a clk edge):
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Overrides cancel and start.
  - Reset mid-operation discards the operation with no HI/LO update.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start with MULT/MULTU/DIV/DIVU: latch operands and op, take operand magnitudes for signed ops, record signs, set counter=0, go to RUN. busy=1 from the next cycle.
  - start with MTHI/MTLO: write opA into hi or lo at that edge. busy stays 0, done is not asserted.
  - Undefined op codes are ignored.
- RUN: one iteration per cycle for WIDTH cycles, then go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX, one cycle:
  - Apply sign correction. Product is negated if sign(opA) xor sign(opB), signed multiply only.
  - Quotient sign = sign(opA) xor sign(opB). Remainder sign = sign(opA).
  - Write hi/lo at the FIX exit edge; busy=0 and done=1 in the following cycle.
- Latency: start accepted at edge E0; done=1 and the new hi/lo are visible in cycle E0+WIDTH+2, i.e. 34 cycles for WIDTH=32. busy is high for exactly WIDTH+1 cycles.
- Multiply result: hi = upper WIDTH bits, lo = lower WIDTH bits of the full product.
- Divide result: lo = quotient, hi = remainder.
- Divisor zero, signed or unsigned: lo = all ones, hi = opA unmodified. Forced in FIX; latency unchanged.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural result of truncating the magnitude arithmetic.
- start while busy=1: ignored, including MTHI/MTLO. The initiator is responsible for stalling.
- cancel while busy:
  - Return to IDLE at that edge; HI/LO retain their pre-operation values; no done.
  - cancel in IDLE has no effect.
  - cancel together with start in IDLE: start is ignored.
- cancel in FIX: the result is dropped and done is not asserted.
- done is never asserted in two consecutive cycles.

Decomposition:
- ISA.v holds the MD_* op-code constants alongside the existing opcode/funct definitions, and the WIDTH default.
- One natural sub-module: md_sign_fix, the combinational magnitude/negate helper used at entry and in FIX.
- The iteration datapath and FSM stay in mul_div_unit.

Test Plan:
- MULTU opA=0xFFFFFFFF, opB=2 -> hi=0x00000001, lo=0xFFFFFFFE; done exactly 34 cycles after the start edge; busy high for 33 cycles.
- MULT opA=0xFFFFFFFF (-1), opB=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULT 0xdead0000 x 0x0000beef must match the 64-bit signed product.
- DIV opA=-7 (0xFFFFFFF9), opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU opA=5, opB=0 -> lo=0xFFFFFFFF, hi=5, with normal latency.
- MTHI 0xdeadbeef then MTLO 0x0000beef on consecutive cycles -> hi/lo update on each edge; busy and done stay 0.
- Start MULT 3x4, then:
  - assert a second start at cycle 5 -> ignored; result lo=12.
  - repeat with cancel at cycle 10 -> busy drops next cycle, hi/lo unchanged, no done.
  - repeat with rstN=0 at cycle 20 -> hi=lo=0, busy=0.
